// File: rtl/spi_sd_cmd_master.sv
// SPI mode-0 master: sends one 48-bit SD command frame, waits for the
// response start bit (with timeout), then captures RESP_BITS response bits.
// Ports:
//   clk, rst          system clock, async active-high reset
//   start             request a transaction (sampled only when idle)
//   cmd_index/arg/crc command fields packed into the outgoing frame
//   cs_hold           keep cs low after this transaction completes
//   busy, done        transaction in flight / one-cycle completion pulse
//   timed_out         no start bit seen; valid with done, held until start
//   resp_data         captured response, first received bit in the MSB
//   sclk, mosi, miso  SPI pins (CPOL=0, CPHA=0)
//   cs                chip select, active low
module spi_sd_cmd_master #(
   parameter int CLK_DIV   = 4,
   parameter int RESP_BITS = 24,
   parameter int NCR_MAX   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [5:0]           cmd_index,
   input  logic [31:0]          cmd_arg,
   input  logic [6:0]           cmd_crc,
   input  logic                 cs_hold,
   output logic                 busy,
   output logic                 done,
   output logic                 timed_out,
   output logic [RESP_BITS-1:0] resp_data,
   output logic                 sclk,
   output logic                 mosi,
   input  logic                 miso,
   output logic                 cs
);

   localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CMAX = (8 * NCR_MAX > 64) ? 8 * NCR_MAX : 64;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_RECV,
      S_FINISH
   } state_t;

   state_t                 r_state, w_state_d;
   logic [DW-1:0]          r_div, w_div_d;
   logic                   r_sclk, w_sclk_d;
   logic                   r_mosi, w_mosi_d;
   logic                   r_cs, w_cs_d;
   logic                   r_busy, w_busy_d;
   logic                   r_done, w_done_d;
   logic                   r_to, w_to_d;
   logic                   r_tflag, w_tflag_d;
   logic                   r_hold, w_hold_d;
   logic [RESP_BITS-1:0]   r_resp, w_resp_d;
   logic [RESP_BITS-1:0]   r_shift, w_shift_d;
   logic [46:0]            r_frame, w_frame_d;
   logic [CW-1:0]          r_cnt, w_cnt_d;

   logic [47:0]            w_frame_in;
   logic                   w_tick;
   logic                   w_rise;
   logic                   w_fall;

   assign w_frame_in = {2'b01, cmd_index, cmd_arg, cmd_crc, 1'b1};
   assign w_tick     = (r_div == DW'(CLK_DIV - 1));
   assign w_rise     = w_tick & ~r_sclk;
   assign w_fall     = w_tick & r_sclk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b1;
         r_cs    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_to    <= 1'b0;
         r_tflag <= 1'b0;
         r_hold  <= 1'b0;
         r_resp  <= '0;
         r_shift <= '0;
         r_frame <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_div   <= w_div_d;
         r_sclk  <= w_sclk_d;
         r_mosi  <= w_mosi_d;
         r_cs    <= w_cs_d;
         r_busy  <= w_busy_d;
         r_done  <= w_done_d;
         r_to    <= w_to_d;
         r_tflag <= w_tflag_d;
         r_hold  <= w_hold_d;
         r_resp  <= w_resp_d;
         r_shift <= w_shift_d;
         r_frame <= w_frame_d;
         r_cnt   <= w_cnt_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_div_d   = r_div;
      w_sclk_d  = r_sclk;
      w_mosi_d  = r_mosi;
      w_cs_d    = r_cs;
      w_busy_d  = r_busy;
      w_done_d  = 1'b0;
      w_to_d    = r_to;
      w_tflag_d = r_tflag;
      w_hold_d  = r_hold;
      w_resp_d  = r_resp;
      w_shift_d = r_shift;
      w_frame_d = r_frame;
      w_cnt_d   = r_cnt;

      // SCLK generator runs only while a transfer is on the wire
      if (r_state == S_SEND || r_state == S_WAIT || r_state == S_RECV) begin
         w_div_d = w_tick ? '0 : r_div + 1'b1;
         if (w_tick) begin
            w_sclk_d = ~r_sclk;
         end
      end

      unique case (r_state)
         S_IDLE: begin
            w_div_d = '0;
            if (start) begin
               w_state_d = S_SEND;
               w_frame_d = w_frame_in[46:0];
               w_mosi_d  = w_frame_in[47];
               w_hold_d  = cs_hold;
               w_cs_d    = 1'b0;
               w_busy_d  = 1'b1;
               w_to_d    = 1'b0;
               w_tflag_d = 1'b0;
               w_shift_d = '0;
               w_cnt_d   = '0;
            end
         end
         S_SEND: begin
            if (w_rise) begin
               w_cnt_d = r_cnt + 1'b1;
            end else if (w_fall) begin
               if (r_cnt == CW'(48)) begin
                  w_state_d = S_WAIT;
                  w_mosi_d  = 1'b1;
                  w_cnt_d   = '0;
               end else begin
                  w_mosi_d  = r_frame[46];
                  w_frame_d = {r_frame[45:0], 1'b0};
               end
            end
         end
         S_WAIT: begin
            if (w_rise) begin
               if (!miso) begin
                  w_shift_d = {r_shift[RESP_BITS-2:0], miso};
                  w_cnt_d   = CW'(1);
                  w_state_d = S_RECV;
               end else begin
                  w_cnt_d = r_cnt + 1'b1;
                  if (r_cnt == CW'(8 * NCR_MAX - 1)) begin
                     w_tflag_d = 1'b1;
                  end
               end
            end else if (w_fall && r_tflag) begin
               // leave only with sclk low so the pins idle cleanly
               w_state_d = S_FINISH;
            end
         end
         S_RECV: begin
            if (w_rise) begin
               w_shift_d = {r_shift[RESP_BITS-2:0], miso};
               w_cnt_d   = r_cnt + 1'b1;
            end else if (w_fall && r_cnt == CW'(RESP_BITS)) begin
               w_state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            w_state_d = S_IDLE;
            w_done_d  = 1'b1;
            w_busy_d  = 1'b0;
            w_cs_d    = ~r_hold;
            w_to_d    = r_tflag;
            w_resp_d  = r_tflag ? '1 : r_shift;
            w_div_d   = '0;
            w_sclk_d  = 1'b0;
            w_mosi_d  = 1'b1;
         end
         default: begin
            w_state_d = S_IDLE;
         end
      endcase
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign timed_out = r_to;
   assign resp_data = r_resp;
   assign sclk      = r_sclk;
   assign mosi      = r_mosi;
   assign cs        = r_cs;

endmodule

// File: tb/tb_spi_sd_cmd_master.sv
// Testbench for spi_sd_cmd_master: a table of directed transactions plus
// randomized ones, checked against a frame/latency/response model.
module tb_spi_sd_cmd_master;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [6:0]  cmd_crc;
   logic        cs_hold;

   logic        start0, miso0, busy0, done0, to0, sclk0, mosi0, cs0;
   logic [23:0] resp0;
   logic        start1, miso1, busy1, done1, to1, sclk1, mosi1, cs1;
   logic [7:0]  resp1;

   int n_cmp = 0;
   int n_bad = 0;
   bit prev_hold [2];

   always #5 clk = ~clk;

   spi_sd_cmd_master #(.CLK_DIV(4), .RESP_BITS(24), .NCR_MAX(8)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0),
      .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc),
      .cs_hold(cs_hold), .busy(busy0), .done(done0), .timed_out(to0),
      .resp_data(resp0), .sclk(sclk0), .mosi(mosi0), .miso(miso0),
      .cs(cs0)
   );

   spi_sd_cmd_master #(.CLK_DIV(1), .RESP_BITS(8), .NCR_MAX(2)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1),
      .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc),
      .cs_hold(cs_hold), .busy(busy1), .done(done1), .timed_out(to1),
      .resp_data(resp1), .sclk(sclk1), .mosi(mosi1), .miso(miso1),
      .cs(cs1)
   );

   typedef struct {
      int          d;
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [6:0]  crc;
      logic        hold;
      int          w;
      logic [63:0] rv;
      bit          pulse;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic set_start(input int d, input logic v);
      if (d == 0) start0 = v;
      else        start1 = v;
   endtask

   task automatic set_miso(input int d, input logic v);
      if (d == 0) miso0 = v;
      else        miso1 = v;
   endtask

   // One transaction; the card side is modelled as a bit stream that
   // starts after the 48th SCLK rise: w idle ones, then the response.
   task automatic txn(input int d, input logic [5:0] idx,
                      input logic [31:0] arg, input logic [6:0] crc,
                      input logic hold, input int w,
                      input logic [63:0] rv, input bit pulse);
      int          c, rb, ncr, lat, lat_exp, limit, rcnt, prev_rise, first;
      int          qi;
      bit          q [$];
      logic [47:0] fexp, cap;
      logic [63:0] mask, rbits, rexp, resp;
      logic        to_exp, got, sc, psc, mo, csv, bz, dn, tov;
      bit          bad_busy, bad_cs, bad_sclk, bad_idle;

      c     = (d == 0) ? 4 : 1;
      rb    = (d == 0) ? 24 : 8;
      ncr   = (d == 0) ? 8 : 2;
      fexp  = {2'b01, idx, arg, crc, 1'b1};
      mask  = (64'd1 << rb) - 64'd1;
      rbits = rv & (mask >> 1);
      to_exp = (w >= 8 * ncr);
      rexp  = to_exp ? mask : rbits;
      lat_exp = to_exp ? 2 * c * (48 + 8 * ncr) + 2
                       : 2 * c * (48 + w + rb) + 2;
      limit = lat_exp + 40;
      for (int i = 0; i < w; i++) q.push_back(1'b1);
      for (int b = rb - 1; b >= 0; b--) q.push_back(rbits[b]);
      qi = 0; rcnt = 0; prev_rise = 0; first = 0; cap = '0;
      bad_busy = 0; bad_cs = 0; bad_sclk = 0; got = 0; psc = 1'b0;

      @(negedge clk);
      chk("cs_idle", 64'((d == 0) ? cs0 : cs1), 64'(!prev_hold[d]));
      cmd_index = idx; cmd_arg = arg; cmd_crc = crc; cs_hold = hold;
      set_miso(d, 1'b1);
      set_start(d, 1'b1);
      lat = 0;
      for (int k = 0; k < limit; k++) begin
         @(posedge clk);
         lat++;
         #1;
         if (lat == 1) set_start(d, 1'b0);
         sc  = (d == 0) ? sclk0 : sclk1;
         mo  = (d == 0) ? mosi0 : mosi1;
         csv = (d == 0) ? cs0   : cs1;
         bz  = (d == 0) ? busy0 : busy1;
         dn  = (d == 0) ? done0 : done1;
         if (sc && !psc) begin
            rcnt++;
            if (rcnt <= 48) cap = {cap[46:0], mo};
            if (rcnt == 1) first = lat;
            else if (lat - prev_rise != 2 * c) bad_sclk = 1;
            prev_rise = lat;
         end
         if (!sc && psc && rcnt >= 48) begin
            if (qi < q.size()) begin
               set_miso(d, q[qi]);
               qi++;
            end else begin
               set_miso(d, 1'b1);
            end
         end
         psc = sc;
         if (dn) begin
            got = 1;
            chk("busy_at_done", 64'(bz), 64'd0);
            break;
         end
         if (!bz) bad_busy = 1;
         if (csv) bad_cs = 1;
         if (pulse && lat == 60) set_start(d, 1'b1);
         if (pulse && lat == 61) set_start(d, 1'b0);
      end
      set_start(d, 1'b0);
      set_miso(d, 1'b1);
      resp = (d == 0) ? 64'(resp0) : 64'(resp1);
      tov  = (d == 0) ? to0 : to1;
      chk("done_seen", 64'(got), 64'd1);
      chk("latency", 64'(lat), 64'(lat_exp));
      chk("mosi_frame", 64'(cap), 64'(fexp));
      chk("resp_data", resp, rexp);
      chk("timed_out", 64'(tov), 64'(to_exp));
      chk("first_rise", 64'(first), 64'(c + 1));
      chk("sclk_period", 64'(bad_sclk), 64'd0);
      chk("busy_cont", 64'(bad_busy), 64'd0);
      chk("cs_low", 64'(bad_cs), 64'd0);
      @(posedge clk);
      #1;
      chk("done_pulse", 64'((d == 0) ? done0 : done1), 64'd0);
      chk("cs_after", 64'((d == 0) ? cs0 : cs1), 64'(!hold));
      bad_idle = 0;
      repeat (6 * c) begin
         @(posedge clk);
         #1;
         if (d == 0 && (busy0 || done0)) bad_idle = 1;
         if (d == 1 && (busy1 || done1)) bad_idle = 1;
      end
      chk("no_requeue", 64'(bad_idle), 64'd0);
      prev_hold[d] = hold;
   endtask

   initial begin
      bit   bad;
      vec_t v;

      vecs[0] = '{0, 6'd17, 32'h0, 7'h0, 1'b0, 16, 64'h5A5A5A, 1'b0};
      vecs[1] = '{0, 6'd17, 32'h1000, 7'h2A, 1'b0, 64, 64'h123456, 1'b0};
      vecs[2] = '{0, 6'd18, 32'h00000200, 7'h55, 1'b1, 3, 64'h123456, 1'b0};
      vecs[3] = '{0, 6'd12, 32'h0, 7'h30, 1'b0, 1, 64'h7FFFFF, 1'b0};
      vecs[4] = '{0, 6'd17, 32'hDEADBEEF, 7'h11, 1'b0, 5, 64'h00ABCD, 1'b1};
      vecs[5] = '{1, 6'd17, 32'hA5A5A5A5, 7'h7F, 1'b0, 0, 64'h3C, 1'b0};
      vecs[6] = '{1, 6'd17, 32'h0, 7'h0, 1'b0, 16, 64'h3C, 1'b0};

      rst = 1'b1;
      start0 = 0; start1 = 0; miso0 = 1; miso1 = 1;
      cmd_index = '0; cmd_arg = '0; cmd_crc = '0; cs_hold = 0;
      prev_hold[0] = 0; prev_hold[1] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sclk0", 64'(sclk0), 64'd0);
      chk("rst_mosi0", 64'(mosi0), 64'd1);
      chk("rst_cs0", 64'(cs0), 64'd1);
      chk("rst_busy0", 64'(busy0), 64'd0);
      chk("rst_done0", 64'(done0), 64'd0);
      chk("rst_to0", 64'(to0), 64'd0);
      chk("rst_resp0", 64'(resp0), 64'd0);
      chk("rst_cs1", 64'(cs1), 64'd1);
      chk("rst_resp1", 64'(resp1), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // reset mid-SEND with start held high throughout
      @(negedge clk);
      cmd_index = 6'd17; cmd_arg = 32'h55; cmd_crc = 7'h1; cs_hold = 0;
      start0 = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("midsend_cs", 64'(cs0), 64'd0);
      #1;
      rst = 1'b1;
      #1;
      chk("rstmid_cs", 64'(cs0), 64'd1);
      chk("rstmid_sclk", 64'(sclk0), 64'd0);
      chk("rstmid_mosi", 64'(mosi0), 64'd1);
      chk("rstmid_busy", 64'(busy0), 64'd0);
      bad = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done0) bad = 1;
      end
      chk("rstmid_nodone", 64'(bad), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("restart_busy", 64'(busy0), 64'd1);
      chk("restart_cs", 64'(cs0), 64'd0);
      start0 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         txn(v.d, v.idx, v.arg, v.crc, v.hold, v.w, v.rv, v.pulse);
      end

      for (int i = 0; i < 16; i++) begin
         v.d     = int'($urandom_range(0, 1));
         v.idx   = 6'($urandom);
         v.arg   = $urandom;
         v.crc   = 7'($urandom);
         v.hold  = 1'($urandom);
         v.w     = int'($urandom_range(0, (v.d == 0) ? 66 : 18));
         v.rv    = {$urandom, $urandom};
         v.pulse = 1'($urandom);
         txn(v.d, v.idx, v.arg, v.crc, v.hold, v.w, v.rv, v.pulse);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
